// File: rtl/alu_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter_pkg
// Shared types and constants for the ALU request arbiter.
//   arb_state_e  : sequencer states (IDLE -> ISSUE -> WAIT -> RESP)
//   CMD_MUL_*    : commands that take the longer multiply latency (MODE=1)
//   FLAG_*       : bit positions inside RSP_FLAGS = {ERR,OFLOW,COUT,G,L,E}
//   is_mul_op()  : selects the multiply latency for a MODE/CMD pair
// -----------------------------------------------------------------------------
package alu_req_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic [3:0] CMD_MUL_INC = 4'd9;
    localparam logic [3:0] CMD_MUL_SHL = 4'd10;

    localparam int N_FLAGS    = 6;
    localparam int FLAG_ERR   = 5;
    localparam int FLAG_OFLOW = 4;
    localparam int FLAG_COUT  = 3;
    localparam int FLAG_G     = 2;
    localparam int FLAG_L     = 1;
    localparam int FLAG_E     = 0;

    // Multiply commands only exist in arithmetic mode (MODE=1).
    function automatic logic is_mul_op(input logic mode, input logic [3:0] cmd);
        return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
    endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_grant.sv
// -----------------------------------------------------------------------------
// alu_rr_grant
// Combinational round-robin grant. Picks the first set bit of 'valid'
// searching ptr, ptr+1, ... wrapping modulo N_REQ.
//   valid [N_REQ]        : request vector
//   ptr   [$clog2(N_REQ)]: highest-priority index (must be < N_REQ)
//   grant [N_REQ]        : one-hot grant (all zero when nothing valid)
//   idx   [$clog2(N_REQ)]: index of the granted requester
//   any                  : at least one request is valid
// -----------------------------------------------------------------------------
module alu_rr_grant #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         valid,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     any
);

    localparam int IW = $clog2(N_REQ);

    always_comb begin : p_grant
        logic [IW-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // Modulo (not bit truncation) so non power-of-two N_REQ wraps correctly.
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
// Shares one ALU between N_REQ requesters. A round-robin grant accepts one
// operation at a time, drives it on the ALU bus with CE for a command-dependent
// fixed latency, captures RES/flags and returns them tagged with the
// requester index on a valid/ready response channel.
//
// Ports
//   CLK, RST (async, active high)
//   REQ_VALID/REQ_READY [N_REQ]   : request handshake, READY is one-hot, comb.
//   REQ_OPA/OPB [N_REQ*WIDTH], REQ_CMD [N_REQ*4], REQ_MODE/REQ_CIN [N_REQ],
//   REQ_INP_VALID [N_REQ*2]       : packed per-requester fields, slice i = req i
//   ALU_OPA/OPB/CMD/MODE/CIN/INP_VALID/CE : registered ALU input bus
//   ALU_RES [2*WIDTH], ALU_ERR/OFLOW/COUT/G/L/E : ALU outputs
//   RSP_VALID/RSP_READY, RSP_ID, RSP_RES, RSP_FLAGS {ERR,OFLOW,COUT,G,L,E}
// -----------------------------------------------------------------------------
module alu_req_arbiter
    import alu_req_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int BASE_LAT = 1,
    parameter int MUL_LAT  = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    // request side
    input  logic [N_REQ-1:0]         REQ_VALID,
    output logic [N_REQ-1:0]         REQ_READY,
    input  logic [N_REQ*WIDTH-1:0]   REQ_OPA,
    input  logic [N_REQ*WIDTH-1:0]   REQ_OPB,
    input  logic [N_REQ*4-1:0]       REQ_CMD,
    input  logic [N_REQ-1:0]         REQ_MODE,
    input  logic [N_REQ-1:0]         REQ_CIN,
    input  logic [N_REQ*2-1:0]       REQ_INP_VALID,
    // ALU input bus
    output logic [WIDTH-1:0]         ALU_OPA,
    output logic [WIDTH-1:0]         ALU_OPB,
    output logic [3:0]               ALU_CMD,
    output logic                     ALU_MODE,
    output logic                     ALU_CIN,
    output logic                     ALU_CE,
    output logic [1:0]               ALU_INP_VALID,
    // ALU outputs
    input  logic [2*WIDTH-1:0]       ALU_RES,
    input  logic                     ALU_ERR,
    input  logic                     ALU_OFLOW,
    input  logic                     ALU_COUT,
    input  logic                     ALU_G,
    input  logic                     ALU_L,
    input  logic                     ALU_E,
    // response side
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic [$clog2(N_REQ)-1:0] RSP_ID,
    output logic [2*WIDTH-1:0]       RSP_RES,
    output logic [N_FLAGS-1:0]       RSP_FLAGS
);

    localparam int IW      = $clog2(N_REQ);
    localparam int MAX_LAT = (MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT;
    localparam int LW      = $clog2(MAX_LAT + 1);

    typedef struct packed {
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
        logic [3:0]       cmd;
        logic             mode;
        logic             cin;
        logic [1:0]       inp_valid;
    } alu_req_t;

    arb_state_e              state, state_d;
    alu_req_t [N_REQ-1:0]    req_in;
    alu_req_t                bus_q;
    logic [N_REQ-1:0]        gnt;
    logic [IW-1:0]           gnt_idx;
    logic                    gnt_any;
    logic                    xfer;
    logic [IW-1:0]           ptr;
    logic [IW-1:0]           id_q;
    logic [LW-1:0]           lat_cnt;
    logic                    ce_q;
    logic                    rsp_vld_q;
    logic [IW-1:0]           rsp_id_q;
    logic [2*WIDTH-1:0]      rsp_res_q;
    logic [N_FLAGS-1:0]      rsp_flags_q;

    // ---- unpack requester slices ------------------------------------------
    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        assign req_in[i] = '{
            opa:       REQ_OPA[i*WIDTH +: WIDTH],
            opb:       REQ_OPB[i*WIDTH +: WIDTH],
            cmd:       REQ_CMD[i*4 +: 4],
            mode:      REQ_MODE[i],
            cin:       REQ_CIN[i],
            inp_valid: REQ_INP_VALID[i*2 +: 2]
        };
    end

    // ---- arbitration ------------------------------------------------------
    alu_rr_grant #(.N_REQ(N_REQ)) u_grant (
        .valid (REQ_VALID),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Grants are only offered while idle, so READY doubles as "accepted".
    assign REQ_READY = ((state == IDLE) && !RST) ? gnt : '0;

    // ---- FSM --------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        xfer    = 1'b0;
        case (state)
            IDLE:  if (gnt_any) begin
                       state_d = ISSUE;
                       xfer    = 1'b1;
                   end
            ISSUE: state_d = WAIT;
            WAIT:  if (lat_cnt == LW'(1)) state_d = RESP;
            RESP:  if (RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- datapath ---------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus_q       <= '0;
            id_q        <= '0;
            ptr         <= '0;
            lat_cnt     <= '0;
            ce_q        <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            // CE and RSP_VALID follow the next state so they are flop outputs
            // aligned with the state they describe.
            ce_q      <= (state_d == ISSUE) || (state_d == WAIT);
            rsp_vld_q <= (state_d == RESP);

            // Bus is loaded at the handshake and held until the next one.
            if (xfer) begin
                bus_q <= req_in[gnt_idx];
                id_q  <= gnt_idx;
            end

            if (state == ISSUE)
                lat_cnt <= is_mul_op(bus_q.mode, bus_q.cmd) ? LW'(MUL_LAT) : LW'(BASE_LAT);
            else if (state == WAIT)
                lat_cnt <= lat_cnt - LW'(1);

            // Last WAIT cycle: the ALU result is valid now.
            if ((state == WAIT) && (lat_cnt == LW'(1))) begin
                rsp_res_q   <= ALU_RES;
                rsp_flags_q <= {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E};
                rsp_id_q    <= id_q;
            end

            // Pointer moves past the requester just served only once its
            // response has been taken.
            if ((state == RESP) && RSP_READY)
                ptr <= (id_q == IW'(N_REQ - 1)) ? '0 : id_q + IW'(1);
        end
    end

    // ---- outputs ----------------------------------------------------------
    assign ALU_OPA       = bus_q.opa;
    assign ALU_OPB       = bus_q.opb;
    assign ALU_CMD       = bus_q.cmd;
    assign ALU_MODE      = bus_q.mode;
    assign ALU_CIN       = bus_q.cin;
    assign ALU_INP_VALID = bus_q.inp_valid;
    assign ALU_CE        = ce_q;

    assign RSP_VALID     = rsp_vld_q;
    assign RSP_ID        = rsp_id_q;
    assign RSP_RES       = rsp_res_q;
    assign RSP_FLAGS     = rsp_flags_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_req_arbiter
// Directed bench for alu_req_arbiter with a behavioural ALU whose result only
// becomes valid after the command latency; expected responses are queued when
// requests are driven and compared when the response handshake happens.
// -----------------------------------------------------------------------------
module tb_alu_req_arbiter;
    import alu_req_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] res;
        logic [5:0]  flags;
    } exp_t;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   REQ_VALID = '0;
    logic [N-1:0]   REQ_READY;
    logic [N*W-1:0] REQ_OPA = '0;
    logic [N*W-1:0] REQ_OPB = '0;
    logic [N*4-1:0] REQ_CMD = '0;
    logic [N-1:0]   REQ_MODE = '0;
    logic [N-1:0]   REQ_CIN = '0;
    logic [N*2-1:0] REQ_INP_VALID = '0;
    logic [W-1:0]   ALU_OPA, ALU_OPB;
    logic [3:0]     ALU_CMD;
    logic           ALU_MODE, ALU_CIN, ALU_CE;
    logic [1:0]     ALU_INP_VALID;
    logic [15:0]    ALU_RES;
    logic           ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E;
    logic           RSP_VALID;
    logic           RSP_READY = 1'b0;
    logic [1:0]     RSP_ID;
    logic [15:0]    RSP_RES;
    logic [5:0]     RSP_FLAGS;

    int   tests = 0;
    int   fails = 0;
    int   ce_cnt = 0;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    alu_req_arbiter #(.N_REQ(N), .WIDTH(W), .BASE_LAT(1), .MUL_LAT(2)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CMD(REQ_CMD),
        .REQ_MODE(REQ_MODE), .REQ_CIN(REQ_CIN), .REQ_INP_VALID(REQ_INP_VALID),
        .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CMD(ALU_CMD),
        .ALU_MODE(ALU_MODE), .ALU_CIN(ALU_CIN), .ALU_CE(ALU_CE),
        .ALU_INP_VALID(ALU_INP_VALID),
        .ALU_RES(ALU_RES), .ALU_ERR(ALU_ERR), .ALU_OFLOW(ALU_OFLOW),
        .ALU_COUT(ALU_COUT), .ALU_G(ALU_G), .ALU_L(ALU_L), .ALU_E(ALU_E),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS)
    );

    // Small ALU reference: {flags, res}
    function automatic logic [21:0] alu_model(input logic mode, input logic [3:0] cmd,
                                              input logic [7:0] a, input logic [7:0] b,
                                              input logic cin, input logic [1:0] iv);
        logic [15:0] r;
        logic [5:0]  f;
        r = '0;
        f = '0;
        if (iv == 2'b00) f[5] = 1'b1;
        else if (mode) begin
            case (cmd)
                4'd0:  begin r = 16'(a) + 16'(b) + 16'(cin); f[3] = r[8]; end
                4'd9:  r = (16'(a) + 16'd1) * (16'(b) + 16'd1);
                4'd10: r = (16'(a) << 1) * 16'(b);
                default: r = {8'h00, a ^ b};
            endcase
        end else r = {8'h00, a & b};
        return {f, r};
    endfunction

    // Behavioural ALU: result is garbage until the command latency has elapsed
    // since CE rose, so a capture on the wrong cycle shows up as a bad value.
    always @(negedge CLK) ce_cnt <= ALU_CE ? ce_cnt + 1 : 0;

    always_comb begin
        logic [21:0] m;
        int          lat;
        m   = alu_model(ALU_MODE, ALU_CMD, ALU_OPA, ALU_OPB, ALU_CIN, ALU_INP_VALID);
        lat = (ALU_MODE && (ALU_CMD == 4'd9 || ALU_CMD == 4'd10)) ? 2 : 1;
        if (ce_cnt > lat) begin
            ALU_RES = m[15:0];
            {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E} = m[21:16];
        end else begin
            ALU_RES = 16'hDEAD;
            {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E} = 6'h2A;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int id, input logic mode, input logic [3:0] cmd,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [1:0] iv);
        REQ_OPA[id*W +: W]     = a;
        REQ_OPB[id*W +: W]     = b;
        REQ_CMD[id*4 +: 4]     = cmd;
        REQ_MODE[id]           = mode;
        REQ_CIN[id]            = cin;
        REQ_INP_VALID[id*2 +: 2] = iv;
    endtask

    task automatic push(input int id, input logic mode, input logic [3:0] cmd,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [1:0] iv);
        logic [21:0] m;
        exp_t        e;
        m = alu_model(mode, cmd, a, b, cin, iv);
        e.id    = 2'(id);
        e.res   = m[15:0];
        e.flags = m[21:16];
        sb.push_back(e);
    endtask

    // Single request, RSP_READY high; checks grant, CE window and latency.
    task automatic run_op(input int id, input logic mode, input logic [3:0] cmd,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [1:0] iv, input int lat);
        int   cyc;
        logic seen;
        tick;
        set_req(id, mode, cmd, a, b, cin, iv);
        REQ_VALID = 4'(1 << id);
        RSP_READY = 1'b1;
        push(id, mode, cmd, a, b, cin, iv);
        @(negedge CLK);
        chk("op_grant", REQ_READY, 32'(1 << id));
        tick;
        REQ_VALID = '0;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge CLK);
            if (RSP_VALID) seen = 1'b1;
            else begin
                chk("op_ce_busy", ALU_CE, 1);
                tick;
                cyc++;
            end
        end
        chk("op_rsp_latency", cyc, lat + 2);
        chk("op_ce_off_in_resp", ALU_CE, 0);
        tick;
    endtask

    task automatic drain;
        for (int k = 0; k < 60 && sb.size() != 0; k++) tick;
        chk("sb_drain", sb.size(), 0);
    endtask

    // Scoreboard: compare on every response handshake.
    always @(negedge CLK) begin : mon
        exp_t e;
        if (!RST && RSP_VALID && RSP_READY) begin
            if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                chk("sb_id", RSP_ID, e.id);
                chk("sb_res", RSP_RES, e.res);
                chk("sb_flags", RSP_FLAGS, e.flags);
            end
        end
    end

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        int   ord [5];
        logic got;

        // ---- reset state --------------------------------------------------
        REQ_VALID = '1;
        RSP_READY = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_req_ready", REQ_READY, 0);
        chk("rst_alu_ce", ALU_CE, 0);
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_alu_bus", {ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, ALU_INP_VALID}, 0);
        chk("rst_rsp_bus", {RSP_ID, RSP_RES, RSP_FLAGS}, 0);
        tick;
        REQ_VALID = '0;
        RST = 1'b0;

        // ---- fairness: all valid, strict rotation 0,1,2,3,0 ---------------
        tick;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'd0, 8'(8'h10 * i + 1), 8'(i), 1'b0, 2'b11);
        REQ_VALID = '1;
        RSP_READY = 1'b1;
        for (int g = 0; g < 5; g++) begin
            ord[g] = g % N;
            push(ord[g], 1'b1, 4'd0, 8'(8'h10 * ord[g] + 1), 8'(ord[g]), 1'b0, 2'b11);
        end
        for (int g = 0; g < 5; g++) begin
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge CLK);
                if (REQ_READY != '0) got = 1'b1;
                else tick;
            end
            chk("fair_grant", REQ_READY, 32'(1 << ord[g]));
            tick;
            if (g == 4) REQ_VALID = '0;
        end
        drain;

        // ---- single add on req2 -------------------------------------------
        run_op(2, 1'b1, 4'd0, 8'h0F, 8'h01, 1'b0, 2'b11, 1);
        drain;

        // ---- multiply latency on req0 -------------------------------------
        run_op(0, 1'b1, 4'd9, 8'h03, 8'h04, 1'b0, 2'b11, 2);
        drain;

        // ---- backpressure: req1 held in RESP, req0 waiting ----------------
        tick;
        set_req(1, 1'b1, 4'd0, 8'h21, 8'h12, 1'b1, 2'b11);
        REQ_VALID = 4'b0010;
        RSP_READY = 1'b0;
        push(1, 1'b1, 4'd0, 8'h21, 8'h12, 1'b1, 2'b11);
        @(negedge CLK);
        chk("bp_grant1", REQ_READY, 4'b0010);
        tick;
        set_req(0, 1'b0, 4'd3, 8'hF0, 8'h3C, 1'b0, 2'b11);
        REQ_VALID = 4'b0001;
        push(0, 1'b0, 4'd3, 8'hF0, 8'h3C, 1'b0, 2'b11);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge CLK);
            if (RSP_VALID) got = 1'b1;
            else tick;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", RSP_VALID, 1);
            chk("bp_rsp_res", RSP_RES, 16'h0034);
            chk("bp_rsp_id", RSP_ID, 1);
            chk("bp_req_ready", REQ_READY, 0);
            chk("bp_alu_ce", ALU_CE, 0);
            tick;
            @(negedge CLK);
        end
        tick;
        RSP_READY = 1'b1;
        @(negedge CLK);
        chk("bp_no_grant_in_resp", REQ_READY, 0);
        tick;
        @(negedge CLK);
        chk("bp_grant_resume", REQ_READY, 4'b0001);
        tick;
        REQ_VALID = '0;
        drain;

        // ---- reset mid-op: req1 discarded, pointer back to 0 --------------
        tick;
        set_req(1, 1'b1, 4'd9, 8'h05, 8'h06, 1'b0, 2'b11);
        REQ_VALID = 4'b0010;
        @(negedge CLK);
        chk("rst_mid_grant1", REQ_READY, 4'b0010);
        tick;
        REQ_VALID = '0;
        tick;
        @(negedge CLK);
        chk("rst_mid_in_wait_ce", ALU_CE, 1);
        RST = 1'b1;
        REQ_VALID = '1;
        #1;
        chk("rst_mid_ce", ALU_CE, 0);
        chk("rst_mid_rsp_valid", RSP_VALID, 0);
        chk("rst_mid_alu_bus", {ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, ALU_INP_VALID}, 0);
        chk("rst_mid_req_ready", REQ_READY, 0);
        tick;
        tick;
        RST = 1'b0;
        set_req(0, 1'b1, 4'd10, 8'h03, 8'h05, 1'b0, 2'b11);
        REQ_VALID = 4'b0011;
        push(0, 1'b1, 4'd10, 8'h03, 8'h05, 1'b0, 2'b11);
        @(negedge CLK);
        chk("rst_ptr_zero_grant", REQ_READY, 4'b0001);
        tick;
        REQ_VALID = '0;
        drain;

        // ---- error passthrough on req3 ------------------------------------
        run_op(3, 1'b1, 4'd0, 8'h10, 8'h20, 1'b0, 2'b00, 1);
        drain;
        repeat (3) tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
